cpu_core: RTL and testbench

Parametrised multi-cycle accumulator-free register CPU, the next-generation core of the 8-bit processor. It owns the program counter, register file, instruction memory, data memory and ALU. The core adds a handshaked program-load port, a start/halt run control and a sequencing FSM in place of a free-running PC. It sits at the top of the processor below the system testbench/host that loads programs.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cpu_alu.sv | 31 +++
 rtl/cpu_core.sv | 186 ++++++++++++++++++
 tb/tb_cpu_core.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle register CPU: instruction fields,
// opcode and sequencer state encodings, and opcode classification helpers.
package cpu_pkg;

  localparam int INSN_W = 8;
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 4;
  localparam int RD_MSB = 3;
  localparam int RD_LSB = 2;
  localparam int RS_MSB = 1;
  localparam int RS_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_MOV   = 4'h6,
    OP_LDI   = 4'h7,
    OP_LD    = 4'h8,
    OP_ST    = 4'h9,
    OP_JZ    = 4'hA,
    OP_SHL   = 4'hB,
    OP_SHR   = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_IMM    = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  // Opcodes whose ALU result is written to rd and which update the zero flag.
  function automatic logic alu_writes_rd(opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_MOV, OP_LDI, OP_SHL, OP_SHR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Opcodes that carry a second (immediate) instruction word.
  function automatic logic has_imm(opcode_e op);
    return (op == OP_LDI) || (op == OP_JZ);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: rd-op-rs arithmetic/logic, moves and single-bit shifts.
// Operand a is the rd register, b is rs (or the immediate for LDI).
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (opcode_e'(op))
      OP_ADD:         result = a + b;
      OP_SUB:         result = a - b;
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_MOV, OP_LDI: result = b;
      OP_SHL:         result = {b[DATA_W-2:0], 1'b0};
      OP_SHR:         result = {1'b0, b[DATA_W-1:1]};
      default:        result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle register CPU: handshaked program load into instruction memory,
// start/halt run control and a FETCH/DECODE/IMM/EXEC/MEM sequencer.
module cpu_core
  import cpu_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int NREGS      = 4,
  parameter  int IMEM_DEPTH = 256,
  parameter  int DMEM_DEPTH = 16,
  localparam int PC_W       = $clog2(IMEM_DEPTH),
  localparam int DA_W       = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   pc,
  output logic [7:0]        instruction,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero
);

  localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e state_q;
  state_e state_d;

  logic [INSN_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] regs [NREGS];

  logic [PC_W-1:0]   load_ptr;
  logic [INSN_W-1:0] imm_q;
  logic [DATA_W-1:0] dmem_q;

  opcode_e           op;
  logic [RI_W-1:0]   rd_idx;
  logic [RI_W-1:0]   rs_idx;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   load_ptr_inc;
  logic              start_ok;
  logic              load_fire;
  logic              alu_we;
  logic              ld_re;
  logic              ld_we;
  logic              st_we;
  logic              jz_taken;

  assign op     = opcode_e'(instruction[OP_MSB:OP_LSB]);
  assign rd_idx = instruction[RD_LSB +: RI_W];
  assign rs_idx = instruction[RS_LSB +: RI_W];
  assign rd_val = regs[rd_idx];
  assign rs_val = regs[rs_idx];
  assign alu_b  = (op == OP_LDI) ? DATA_W'(imm_q) : rs_val;

  // Explicit wrap keeps non-power-of-two memory depths well behaved.
  assign pc_inc       = (pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc + 1'b1;
  assign load_ptr_inc = (load_ptr == PC_W'(IMEM_DEPTH - 1)) ? '0 : load_ptr + 1'b1;

  // start is honoured only from IDLE/HALT and never while a load is requested.
  assign start_ok  = start & ~load_en & ((state_q == S_IDLE) | (state_q == S_HALT));
  assign load_fire = load_ready & load_valid;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (instruction[OP_MSB:OP_LSB]),
    .a      (rd_val),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (has_imm(op))         state_d = S_IMM;
        else if (op == OP_HALT)  state_d = S_HALT;
        else                     state_d = S_EXEC;
      end
      S_IMM:    state_d = S_EXEC;
      S_EXEC:   state_d = (op == OP_LD) ? S_MEM : S_FETCH;
      S_MEM:    state_d = S_FETCH;
      S_HALT:   if (start_ok) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    halted     = 1'b0;
    load_ready = 1'b0;
    alu_we     = 1'b0;
    ld_re      = 1'b0;
    ld_we      = 1'b0;
    st_we      = 1'b0;
    jz_taken   = 1'b0;
    case (state_q)
      S_IDLE: load_ready = load_en & ~reset;
      S_HALT: halted = 1'b1;
      S_EXEC: begin
        busy     = 1'b1;
        alu_we   = alu_writes_rd(op);
        ld_re    = (op == OP_LD);
        st_we    = (op == OP_ST);
        jz_taken = (op == OP_JZ) & zero;
      end
      S_MEM: begin
        busy  = 1'b1;
        ld_we = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // Sequencer-owned registers: program counter, load pointer, instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      load_ptr    <= '0;
      instruction <= '0;
    end else begin
      if (start_ok)
        pc <= '0;
      else if ((state_q == S_FETCH) || (state_q == S_IMM))
        pc <= pc_inc;
      else if (jz_taken)
        pc <= PC_W'(imm_q);

      if (start_ok)
        load_ptr <= '0;
      else if (load_fire)
        load_ptr <= load_ptr_inc;

      if (state_q == S_FETCH)
        instruction <= imem[pc];
    end
  end

  // Memories: synchronous reads, contents survive reset.
  always_ff @(posedge clk) begin
    if (load_fire)
      imem[load_ptr] <= load_data;
    if (state_q == S_IMM)
      imm_q <= imem[pc];
    if (st_we)
      dmem[rd_val[DA_W-1:0]] <= rs_val;
    if (ld_re)
      dmem_q <= dmem[rs_val[DA_W-1:0]];
  end

  // Architectural register file and flags; LD writes back one cycle after EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      alu_result <= '0;
      zero       <= 1'b0;
    end else begin
      if (alu_we) begin
        regs[rd_idx] <= alu_res;
        alu_result   <= alu_res;
        zero         <= alu_zero;
      end else if (ld_we) begin
        regs[rd_idx] <= dmem_q;
      end
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed scenarios plus random programs, each compared
// against an instruction-level model of the ISA kept in the bench.
module tb_cpu_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_en, load_valid, start;
  logic [7:0] load_data;

  logic       load_ready, busy, halted, zero;
  logic [7:0] pc, instruction, alu_result;

  logic        load_ready16, busy16, halted16, zero16;
  logic [7:0]  pc16, instruction16;
  logic [15:0] alu_result16;

  int checks   = 0;
  int failures = 0;

  // Instruction-level model state.
  logic [7:0] m_imem [256];
  int         m_dmem [16];
  int         m_regs [4];
  int         m_alu, m_pc, m_lp;
  bit         m_zero;
  logic [7:0] m_insn;

  logic [7:0] prog [$];

  always #5 clk = ~clk;

  cpu_core #(.DATA_W(8)) u_dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .start(start), .busy(busy),
    .halted(halted), .pc(pc), .instruction(instruction),
    .alu_result(alu_result), .zero(zero)
  );

  cpu_core #(.DATA_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready16), .start(start), .busy(busy16),
    .halted(halted16), .pc(pc16), .instruction(instruction16),
    .alu_result(alu_result16), .zero(zero16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_alu = 0; m_zero = 1'b0; m_lp = 0;
  endtask

  // Executes from address 0 to HALT; cycle cost from the per-class CPI table.
  task automatic model_run(output int cyc);
    int p, op, rd, rs, r, steps;
    logic [7:0] w, imm;
    bit done;
    p = 0; cyc = 0; done = 1'b0; steps = 0; w = 8'h00;
    while (!done && steps < 4000) begin
      steps++;
      w  = m_imem[p];
      p  = (p + 1) % 256;
      op = int'(w[7:4]); rd = int'(w[3:2]); rs = int'(w[1:0]);
      r  = -1;
      case (op)
        1:  r = (m_regs[rd] + m_regs[rs]) % 256;
        2:  r = (m_regs[rd] - m_regs[rs] + 256) % 256;
        3:  r = m_regs[rd] & m_regs[rs];
        4:  r = m_regs[rd] | m_regs[rs];
        5:  r = m_regs[rd] ^ m_regs[rs];
        6:  r = m_regs[rs];
        7:  begin imm = m_imem[p]; p = (p + 1) % 256; r = int'(imm); end
        8:  m_regs[rd] = m_dmem[m_regs[rs] % 16];
        9:  m_dmem[m_regs[rd] % 16] = m_regs[rs];
        10: begin imm = m_imem[p]; p = (p + 1) % 256; if (m_zero) p = int'(imm); end
        11: r = (m_regs[rs] * 2) % 256;
        12: r = m_regs[rs] / 2;
        15: done = 1'b1;
        default: ;
      endcase
      if (r >= 0) begin
        m_regs[rd] = r; m_alu = r; m_zero = (r == 0);
      end
      cyc += (op == 15) ? 2 : ((op == 7 || op == 8 || op == 10) ? 4 : 3);
    end
    m_pc = p; m_insn = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load_words(input logic [7:0] words[$], input bit start_too);
    foreach (words[i]) begin
      @(negedge clk);
      if (i == 1 && start_too) check("start_with_load_ignored", busy, 0);
      load_en = 1'b1; load_valid = 1'b1; load_data = words[i];
      start = start_too && (i == 0);
      m_imem[m_lp] = words[i];
      m_lp = (m_lp + 1) % 256;
    end
    @(negedge clk);
    load_en = 1'b0; load_valid = 1'b0; start = 1'b0;
    check("idle_after_load", busy, 0);
  endtask

  // glitch_at >= 0 pulses start at that cycle and load_en two cycles later.
  task automatic run_prog(input string tag, input int glitch_at);
    int exp_cyc, cnt;
    model_run(exp_cyc);
    m_lp = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    cnt = 0;
    while (halted !== 1'b1 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
      start      = (cnt == glitch_at) && (halted !== 1'b1);
      load_en    = (cnt == glitch_at + 2) && (halted !== 1'b1);
      load_valid = load_en;
      load_data  = 8'h00;
      if (glitch_at >= 0 && cnt == glitch_at + 2 && halted !== 1'b1)
        check({tag, "_load_ready_busy"}, load_ready, 0);
    end
    start = 1'b0; load_en = 1'b0; load_valid = 1'b0;
    check({tag, "_cycles"}, cnt, exp_cyc);
    check({tag, "_halted"}, halted, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_alu"}, alu_result, m_alu);
    check({tag, "_zero"}, zero, m_zero);
    check({tag, "_insn"}, instruction, m_insn);
  endtask

  initial begin
    int ops [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 12, 13, 14};
    int o, x;
    reset = 1'b1; load_en = 1'b1; load_valid = 1'b0; load_data = 8'h00; start = 1'b0;
    foreach (m_imem[i]) m_imem[i] = 8'h00;
    foreach (m_dmem[i]) m_dmem[i] = 0;
    model_reset();
    #12;
    check("reset_load_ready", load_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_halted", halted, 0);
    check("reset_pc", pc, 0);
    check("reset_insn", instruction, 0);
    check("reset_alu", alu_result, 0);
    check("reset_zero", zero, 0);
    @(negedge clk);
    reset = 1'b0; load_en = 1'b0;

    // Initialise every data word via LDI/LDI/ST.
    prog.delete();
    for (int a = 0; a < 16; a++) begin
      prog.push_back(8'h70); prog.push_back(8'(a));
      prog.push_back(8'h74); prog.push_back(8'($urandom_range(0, 255)));
      prog.push_back(8'h91);
    end
    prog.push_back(8'hF0);
    load_words(prog, 1'b0);
    run_prog("dmem_init", -1);

    // LDI/LDI/ADD/HALT, with a start pulse coinciding with the first load word.
    do_reset();
    prog = '{8'h71, 8'h05, 8'h75, 8'h03, 8'h14, 8'hF0};
    load_words(prog, 1'b1);
    run_prog("add", -1);
    check("add_alu_const", alu_result, 8);

    // XOR to zero then a taken JZ.
    do_reset();
    prog = '{8'h70, 8'h00, 8'h50, 8'hA0, 8'h20};
    for (int a = 5; a <= 8'h20; a++) prog.push_back(8'hF0);
    load_words(prog, 1'b0);
    run_prog("jz", -1);
    check("jz_zero_const", zero, 1);
    check("jz_pc_const", pc, 8'h21);

    // Store/load round trip through dmem[3].
    do_reset();
    prog = '{8'h74, 8'hA5, 8'h78, 8'h03, 8'h99, 8'h8E, 8'h6F, 8'hF0};
    load_words(prog, 1'b0);
    run_prog("stld", -1);
    check("stld_const", alu_result, 8'hA5);

    // 0xFF + 0x01 wraps to zero.
    do_reset();
    prog = '{8'h70, 8'hFF, 8'h74, 8'h01, 8'h11, 8'hF0};
    load_words(prog, 1'b0);
    run_prog("wrap_add", -1);
    check("wrap_add_alu", alu_result, 0);
    check("wrap_add_zero", zero, 1);

    // 257 loads (the last lands at address 0) and a fetch from PC 255 wrapping to 0.
    do_reset();
    prog = '{8'hFF, 8'h80, 8'h70, 8'h00, 8'hA0, 8'hFF};
    for (int a = 6; a < 255; a++) prog.push_back(8'hF0);
    prog.push_back(8'h00);
    prog.push_back(8'hA0);
    load_words(prog, 1'b0);
    run_prog("pc_wrap", -1);
    check("pc_wrap_const", pc, 8'h81);

    // Reset during EXEC of ADD (tenth state after start).
    do_reset();
    prog = '{8'h71, 8'h05, 8'h75, 8'h03, 8'h14, 8'hF0};
    load_words(prog, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_alu_before", alu_result, 3);
    reset = 1'b1;
    #1;
    check("mid_rst_pc", pc, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_alu", alu_result, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_load_ready", load_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_prog("after_mid_rst", -1);

    // Register file cleared by reset: OR of all registers is zero.
    do_reset();
    prog = '{8'h41, 8'h42, 8'h43, 8'hF0};
    load_words(prog, 1'b0);
    run_prog("regs_clear", -1);

    // load_valid without load_en must not write.
    do_reset();
    @(negedge clk); load_valid = 1'b1; load_data = 8'h00;
    repeat (4) @(negedge clk);
    check("no_en_load_ready", load_ready, 0);
    load_valid = 1'b0;
    run_prog("no_en_load", -1);

    // start and load_en while busy are ignored.
    do_reset();
    prog = '{8'h71, 8'h05, 8'h75, 8'h03, 8'h14, 8'hF0};
    load_words(prog, 1'b0);
    run_prog("glitch", 3);

    // 16-bit build: build 0x8001 then SHL into r2.
    do_reset();
    prog = '{8'h70, 8'h80};
    repeat (8) prog.push_back(8'hB0);
    prog.push_back(8'h74); prog.push_back(8'h01);
    prog.push_back(8'h41); prog.push_back(8'hB8); prog.push_back(8'hF0);
    load_words(prog, 1'b0);
    run_prog("shl8", -1);
    check("shl16_alu", alu_result16, 16'h0002);
    check("shl16_halted", halted16, 1);
    check("shl16_zero", zero16, 0);

    // Random straight-line programs ending in MOV rX,rX; HALT.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      prog.delete();
      for (int k = 0; k < 14; k++) begin
        o = ops[$urandom_range(0, 13)];
        prog.push_back(8'((o << 4) | int'($urandom_range(0, 15))));
        if (o == 7) prog.push_back(8'($urandom_range(0, 255)));
      end
      x = int'($urandom_range(0, 3));
      prog.push_back(8'(8'h60 | (x << 2) | x));
      prog.push_back(8'hF0);
      load_words(prog, 1'b0);
      run_prog($sformatf("rand%0d", t), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
